// File: rtl/cache_memory_responder_if.sv
// ---------------------------------------------------------------------------
// cache_memory_responder_if
//   Block-transfer bus between a cache controller (master) and the memory-side
//   responder (slave).
//
//   Request channel : req_valid/req_ready handshake, req_write selects
//                     write-back (1) or fill (0), req_addr is a byte address.
//   Write channel   : wr_data_valid/wr_data_ready beats of DATA_WIDTH bits,
//                     wr_done pulses once when the whole block is committed.
//   Read channel    : rd_valid/rd_ready beats, rd_last marks the final beat.
//   Status          : busy is high while a transaction is in progress.
// ---------------------------------------------------------------------------
interface cache_memory_responder_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDRESS_WIDTH-1:0] req_addr;

    logic                     wr_data_valid;
    logic                     wr_data_ready;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     wr_done;

    logic                     rd_valid;
    logic                     rd_ready;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_last;

    logic                     busy;

    // Cache controller side
    modport master (
        output req_valid, req_write, req_addr,
        output wr_data_valid, wr_data,
        output rd_ready,
        input  req_ready, wr_data_ready, wr_done,
        input  rd_valid, rd_data, rd_last,
        input  busy
    );

    // Memory responder side
    modport slave (
        input  req_valid, req_write, req_addr,
        input  wr_data_valid, wr_data,
        input  rd_ready,
        output req_ready, wr_data_ready, wr_done,
        output rd_valid, rd_data, rd_last,
        output busy
    );
endinterface

// File: rtl/cache_memory_responder.sv
// ---------------------------------------------------------------------------
// cache_memory_responder
//   Memory-side end of the cache line-fill / write-back protocol. Accepts one
//   block request at a time, models a fixed main-memory latency, then either
//   streams a block out as BEATS read beats or absorbs BEATS write beats and
//   acknowledges the commit with a one-cycle wr_done pulse.
//
//   Ports:
//     clk      - clock
//     reset_n  - synchronous active-low reset (storage contents are kept)
//     bus      - cache_memory_responder_if.slave: request, write-data,
//                write-done, read-data channels and busy status
//
//   Parameter constraints: BEATS = BLOCK_SIZE*8/DATA_WIDTH is a power of two
//   and >= 2; MEM_DEPTH_WORDS is a power of two and a multiple of BEATS;
//   READ_LATENCY and WRITE_LATENCY are >= 1.
// ---------------------------------------------------------------------------
module cache_memory_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int BLOCK_SIZE      = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    cache_memory_responder_if.slave  bus
);
    localparam int BEATS   = BLOCK_SIZE * 8 / DATA_WIDTH;
    localparam int OFF_W   = $clog2(BEATS);
    localparam int IDX_W   = $clog2(MEM_DEPTH_WORDS);
    localparam int BLK_W   = IDX_W - OFF_W;
    localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_WAIT,
        WR_RESP
    } state_t;

    state_t                  state;
    logic [OFF_W-1:0]        beat;
    logic [OFF_W-1:0]        beat_nxt;
    logic [LAT_W-1:0]        lat_cnt;
    logic [BLK_W-1:0]        blk;

    logic                    req_ready_r;
    logic                    wr_data_ready_r;
    logic                    wr_done_r;
    logic                    rd_valid_r;
    logic                    rd_last_r;
    logic [DATA_WIDTH-1:0]   rd_data_r;
    logic                    busy_r;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH_WORDS];

    // Word index of the request; keeping only the block-number bits both
    // drops the block offset and wraps out-of-range addresses.
    logic [ADDRESS_WIDTH-1:0] widx;
    logic [BLK_W-1:0]         req_blk;
    logic                     unused_widx;

    assign widx        = bus.req_addr >> BYTE_SH;
    assign req_blk     = widx[IDX_W-1:OFF_W];
    assign unused_widx = ^widx;

    assign beat_nxt = beat + OFF_W'(1);

    assign bus.req_ready     = req_ready_r;
    assign bus.wr_data_ready = wr_data_ready_r;
    assign bus.wr_done       = wr_done_r;
    assign bus.rd_valid      = rd_valid_r;
    assign bus.rd_last       = rd_last_r;
    assign bus.rd_data       = rd_data_r;
    assign bus.busy          = busy_r;

    // Storage has no reset so contents survive reset_n; a write-back that is
    // cut short by reset keeps the beats already accepted.
    always_ff @(posedge clk) begin
        if (reset_n && state == WR_BURST && bus.wr_data_valid) begin
            mem[{blk, beat}] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            beat            <= '0;
            lat_cnt         <= '0;
            req_ready_r     <= 1'b1;
            wr_data_ready_r <= 1'b0;
            wr_done_r       <= 1'b0;
            rd_valid_r      <= 1'b0;
            rd_last_r       <= 1'b0;
            rd_data_r       <= '0;
            busy_r          <= 1'b0;
        end else begin
            wr_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // req_ready_r is high throughout IDLE
                    if (bus.req_valid) begin
                        blk         <= req_blk;
                        beat        <= '0;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (bus.req_write) begin
                            state           <= WR_BURST;
                            wr_data_ready_r <= 1'b1;
                        end else begin
                            state   <= RD_WAIT;
                            lat_cnt <= LAT_W'(READ_LATENCY - 1);
                        end
                    end
                end

                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        state      <= RD_BURST;
                        rd_valid_r <= 1'b1;
                        rd_last_r  <= 1'b0;
                        rd_data_r  <= mem[{blk, beat}];
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                RD_BURST: begin
                    // Without a handshake every read output simply holds.
                    if (bus.rd_ready) begin
                        beat <= beat_nxt;
                        if (&beat) begin
                            state       <= IDLE;
                            rd_valid_r  <= 1'b0;
                            rd_last_r   <= 1'b0;
                            busy_r      <= 1'b0;
                            req_ready_r <= 1'b1;
                        end else begin
                            rd_data_r <= mem[{blk, beat_nxt}];
                            rd_last_r <= &beat_nxt;
                        end
                    end
                end

                WR_BURST: begin
                    if (bus.wr_data_valid) begin
                        beat <= beat_nxt;
                        if (&beat) begin
                            state           <= WR_WAIT;
                            wr_data_ready_r <= 1'b0;
                            lat_cnt         <= LAT_W'(WRITE_LATENCY - 1);
                        end
                    end
                end

                WR_WAIT: begin
                    if (lat_cnt == '0) begin
                        state     <= WR_RESP;
                        wr_done_r <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                WR_RESP: begin
                    state       <= IDLE;
                    busy_r      <= 1'b0;
                    req_ready_r <= 1'b1;
                end

                default: begin
                    state           <= IDLE;
                    req_ready_r     <= 1'b1;
                    wr_data_ready_r <= 1'b0;
                    rd_valid_r      <= 1'b0;
                    rd_last_r       <= 1'b0;
                    busy_r          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/cache_memory_responder.md
Name: cache_memory_responder

Overview:
- Memory-side responder at the far end of the cache controller's line-fill/write-back protocol.
- Accepts block-granular read (fill) and write (write-back) requests from the cache.
- Models main-memory access latency, then streams or absorbs one block as DATA_WIDTH-wide beats.
- Used as the backing store in cache-level benches and as the template for the real memory port.

Parameters:
- DATA_WIDTH, 32, beat width in bits.
- BLOCK_SIZE, 32, cache block size in bytes. BEATS = BLOCK_SIZE*8/DATA_WIDTH, default 8; must be a power of two, ≥ 2.
- ADDRESS_WIDTH, 32, byte-address width.
- MEM_DEPTH_WORDS, 1024, storage depth in DATA_WIDTH words; must be a power of two and a multiple of BEATS.
- READ_LATENCY, 4, cycles from request acceptance to the first read beat; ≥ 1.
- WRITE_LATENCY, 2, cycles from the last write beat accepted to wr_done; ≥ 1.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, synchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, responder can accept a request.
- req_write, input, 1, 1 = write-back, 0 = fill; sampled with the request.
- req_addr, input, ADDRESS_WIDTH, byte address; block-offset bits ignored.
- wr_data_valid, input, 1, write beat present.
- wr_data_ready, output, 1, write beat accepted when high with wr_data_valid.
- wr_data, input, DATA_WIDTH, write beat data.
- wr_done, output, 1, one-cycle pulse: write-back committed.
- rd_valid, output, 1, read beat present.
- rd_ready, input, 1, cache accepts read beat.
- rd_data, output, DATA_WIDTH, read beat data.
- rd_last, output, 1, high with the final beat of a block.
- busy, output, 1, high in any non-IDLE state.

Behaviour:
- Reset (reset_n low at a clk edge):
  - FSM goes to IDLE.
  - req_ready = 1; wr_data_ready = 0; wr_done = 0; rd_valid = 0; rd_last = 0; rd_data = 0; busy = 0.
  - Beat and latency counters clear.
  - Storage array is not reset; its contents persist across reset.
  - Reset mid-transfer abandons the transfer. A partial write-back leaves its already-written beats in storage.
- Word index: base = (req_addr >> log2(DATA_WIDTH/8)) with the low log2(BEATS) bits cleared, taken modulo MEM_DEPTH_WORDS. Out-of-range addresses wrap; beat k addresses base + k.
- Request handshake: a request is accepted on the edge where req_valid && req_ready. req_ready is high only in IDLE. req_write and req_addr are latched at acceptance.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT, WR_RESP.
- IDLE:
  - Accepted read → RD_WAIT, latency counter loaded with READ_LATENCY-1.
  - Accepted write → WR_BURST, beat counter = 0.
- RD_WAIT:
  - Counter decrements each cycle.
  - At 0 → RD_BURST, with rd_valid = 1 and rd_data = mem[base].
  - The first beat is visible READ_LATENCY cycles after the acceptance edge.
- RD_BURST:
  - rd_valid, rd_data and rd_last hold stable while rd_ready is low.
  - On rd_valid && rd_ready, the beat counter increments and the next word is presented the following cycle (zero bubbles when rd_ready stays high).
  - rd_last = 1 iff beat counter == BEATS-1.
  - Handshake on the last beat → IDLE with rd_valid = 0; req_ready is high the next cycle.
- WR_BURST:
  - wr_data_ready = 1.
  - On wr_data_valid && wr_data_ready, mem[base + beat] ← wr_data and the beat counter increments.
  - Gaps in wr_data_valid are tolerated.
  - After beat BEATS-1 is accepted → WR_WAIT, counter loaded with WRITE_LATENCY-1, wr_data_ready = 0.
- WR_WAIT: counter decrements; at 0 → WR_RESP.
- WR_RESP: wr_done = 1 for exactly one cycle, then → IDLE.
- A read of a block issued after its wr_done returns the new data.
- wr_data_valid outside WR_BURST is ignored. rd_ready outside RD_BURST is ignored.
- Simultaneous events: a request arriving during the cycle the FSM returns to IDLE is accepted only if req_ready was high at that edge. No overlap of transactions; a single outstanding request only.
- Counter widths: beat counter is log2(BEATS) bits and wraps naturally. Latency counter is $clog2(max(READ_LATENCY, WRITE_LATENCY)+1) bits.

Test Plan:
- Write-back then fill:
  - Stimulus: write to addr 0x0000_0040 with beats 0xA0..0xA7, wr_data_valid continuous; then read of 0x0000_0040 with rd_ready = 1.
  - Response: wr_done pulses once, 2 cycles after the 8th beat.
  - Response: rd_valid first rises 4 cycles after the read acceptance; beats 0xA0..0xA7 arrive on 8 consecutive cycles, rd_last only on 0xA7.
- Read backpressure:
  - Stimulus: during the same fill, drop rd_ready for 3 cycles at beat 2.
  - Response: rd_data = 0xA2 and rd_valid hold for all 3 cycles; no beat is lost or duplicated; total of 8 handshakes.
- Offset and wrap:
  - Stimulus: read req_addr 0x0000_005C; then a write to 0x0000_1040 (word index 0x410 wraps to 0x010).
  - Response: the 0x5C read returns the 0x40 block.
  - Response: a subsequent read of 0x40 returns the new data.
- Write data gaps:
  - Stimulus: insert idle cycles between write beats; hold req_valid high during WR_WAIT.
  - Response: all 8 words are stored; req_ready stays 0 until the cycle after wr_done; the held request is accepted then.
- Reset mid-fill:
  - Stimulus: assert reset_n = 0 during beat 4 of a fill.
  - Response: next cycle rd_valid = 0, busy = 0, req_ready = 1.
  - Response: a new read of the same block returns all 8 original words.
